// File: rtl/motor_driver_if.sv
// Command and bridge-pin bundle between the motor controller side and motor_driver.
// Latency: none (wires only). Backpressure: none; the bridge pins are free-running.
interface motor_driver_if;
  logic [4:0] direction;
  logic [7:0] duty;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       in4;
  logic       ena;
  logic       enb;
  logic       active;

  modport master (
    output direction, duty,
    input  in1, in2, in3, in4, ena, enb, active
  );

  modport slave (
    input  direction, duty,
    output in1, in2, in3, in4, ena, enb, active
  );
endinterface

// File: rtl/motor_driver.sv
// Dual H-bridge driver: one-hot command decode, coast dead-time between motion changes, soft-start PWM.
// Latency: 2 edges from direction to pins. Backpressure: none; commands are sampled every cycle.
module motor_driver #(
  parameter int DEAD_CYCLES = 6250000,
  parameter int PWM_DIV     = 24,
  parameter int RAMP_DIV    = 125000
) (
  input logic           clk,
  input logic           reset,
  motor_driver_if.slave drv
);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  typedef enum logic [2:0] {CMD_STOP, CMD_FWD, CMD_BWD, CMD_LEFT, CMD_RIGHT} cmd_t;

  function automatic cmd_t decode(input logic [4:0] d);
    case (d)
      5'b00001: return CMD_FWD;
      5'b00010: return CMD_BWD;
      5'b00100: return CMD_LEFT;
      5'b01000: return CMD_RIGHT;
      default:  return CMD_STOP;
    endcase
  endfunction

  // {in1,in2,in3,in4}
  function automatic logic [3:0] bridge(input cmd_t c);
    case (c)
      CMD_FWD:   return 4'b1010;
      CMD_BWD:   return 4'b0101;
      CMD_LEFT:  return 4'b0110;
      CMD_RIGHT: return 4'b1001;
      default:   return 4'b0000;
    endcase
  endfunction

  state_t        state;
  cmd_t          cur;
  cmd_t          target;
  cmd_t          cmd;
  logic [4:0]    dir_q;
  logic [DW-1:0] dead_cnt;
  logic [PW-1:0] pwm_div_cnt;
  logic [PW-1:0] pwm_div_nxt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    pwm_nxt;
  logic [RW-1:0] ramp_cnt;
  logic [RW-1:0] ramp_nxt;
  logic          ramp_tick;
  logic [7:0]    duty_eff;
  logic [7:0]    duty_run_nxt;
  logic [3:0]    bridge_q;
  logic          ena_q;
  logic          enb_q;
  logic          active_q;

  assign cmd = decode(dir_q);

  // Next-cycle PWM and ramp values, so the registered enables match the registered counters.
  always_comb begin
    pwm_div_nxt  = (pwm_div_cnt == PWM_LAST) ? '0 : pwm_div_cnt + PW'(1);
    pwm_nxt      = (pwm_div_cnt == PWM_LAST) ? pwm_cnt + 8'd1 : pwm_cnt;
    ramp_tick    = (ramp_cnt == RAMP_LAST);
    ramp_nxt     = ramp_tick ? '0 : ramp_cnt + RW'(1);
    duty_run_nxt = duty_eff;
    if (drv.duty < duty_eff)
      duty_run_nxt = drv.duty;
    else if (ramp_tick && (duty_eff < drv.duty))
      duty_run_nxt = duty_eff + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= CMD_STOP;
      target      <= CMD_STOP;
      dir_q       <= '0;
      dead_cnt    <= '0;
      pwm_div_cnt <= '0;
      pwm_cnt     <= '0;
      ramp_cnt    <= '0;
      duty_eff    <= '0;
      bridge_q    <= '0;
      ena_q       <= 1'b0;
      enb_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      dir_q       <= drv.direction;
      pwm_div_cnt <= pwm_div_nxt;
      pwm_cnt     <= pwm_nxt;
      bridge_q    <= '0;
      ena_q       <= 1'b0;
      enb_q       <= 1'b0;
      active_q    <= 1'b0;
      duty_eff    <= '0;
      ramp_cnt    <= '0;
      case (state)
        IDLE: begin
          if (cmd != CMD_STOP) begin
            state    <= RUN;
            cur      <= cmd;
            bridge_q <= bridge(cmd);
            active_q <= 1'b1;
          end
        end
        RUN: begin
          if (cmd == CMD_STOP) begin
            state <= IDLE;
          end else if (cmd != cur) begin
            state    <= DEAD;
            target   <= cmd;
            dead_cnt <= '0;
          end else begin
            bridge_q <= bridge(cur);
            active_q <= 1'b1;
            duty_eff <= duty_run_nxt;
            ramp_cnt <= ramp_nxt;
            ena_q    <= (pwm_nxt < duty_run_nxt);
            enb_q    <= (pwm_nxt < duty_run_nxt);
          end
        end
        DEAD: begin
          // STOP wins over an expiring dead-time; a new target restarts the coast.
          if (cmd == CMD_STOP) begin
            state <= IDLE;
          end else if (cmd != target) begin
            target   <= cmd;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_LAST) begin
            state    <= RUN;
            cur      <= target;
            bridge_q <= bridge(target);
            active_q <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign drv.in1    = bridge_q[3];
  assign drv.in2    = bridge_q[2];
  assign drv.in3    = bridge_q[1];
  assign drv.in4    = bridge_q[0];
  assign drv.ena    = ena_q;
  assign drv.enb    = enb_q;
  assign drv.active = active_q;
endmodule
